// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Access size / sign encoding carried in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Fault causes reported on m_fault_cause.
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_ILLEGAL  = 2'b11;

  // Classifies a memory op before it reaches the bus; FC_NONE means legal
  // (or not a memory op at all).
  function automatic logic [1:0] access_fault(input logic       rd,
                                              input logic       wr,
                                              input logic [2:0] f3,
                                              input logic [1:0] addr);
    logic [1:0] fc;
    fc = FC_NONE;
    if (rd && wr) begin
      fc = FC_ILLEGAL;
    end else if (rd || wr) begin
      case (f3)
        F3_B, F3_BU: fc = FC_NONE;
        F3_H, F3_HU: fc = addr[0] ? FC_MISALIGN : FC_NONE;
        F3_W:        fc = (addr != 2'b00) ? FC_MISALIGN : FC_NONE;
        default:     fc = FC_ILLEGAL;
      endcase
    end
    return fc;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and extends it to 32 bits.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by zero/sign extension.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    data     = '0;
    byte_sel = rdata[7:0];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'b0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'b0, half_sel};
      F3_W:    data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: single-outstanding bus master, stall generation,
// fault detection and the M/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_MemToReg,
  input  logic        m_RegWrite,
  input  logic        m_MemRead,
  input  logic        m_MemWrite,
  input  logic [4:0]  m_rd,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_mem_data,
  output logic        m_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        wb_MemToReg,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_rdata,
  output logic        m_fault,
  output logic [1:0]  m_fault_cause,
  output logic [31:0] m_fault_addr
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        timeout_q, timeout_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic        wb_MemToReg_q, wb_MemToReg_d, wb_RegWrite_q, wb_RegWrite_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_alu_out_q, wb_alu_out_d, wb_mem_rdata_q, wb_mem_rdata_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] faddr_q, faddr_d;

  logic        is_mem, stall_c;
  logic [1:0]  acc_fault;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_data;

  assign is_mem    = m_MemRead | m_MemWrite;
  assign acc_fault = access_fault(m_MemRead, m_MemWrite, m_funct3, m_alu_out[1:0]);
  assign cnt_inc   = cnt_q + CW'(1);

  // Load data is aligned from the captured bus word; EX/M is frozen until DONE.
  lsu_load_align u_align (
    .rdata  (rdata_q),
    .addr   (m_alu_out[1:0]),
    .funct3 (m_funct3),
    .data   (load_data)
  );

  // Byte enables and replicated write data for the current access size.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = m_mem_data;
    case (m_funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << m_alu_out[1:0];
        lane_wdata = {4{m_mem_data[7:0]}};
      end
      2'b01: begin
        lane_be    = m_alu_out[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{m_mem_data[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = m_mem_data;
      end
    endcase
  end

  // Access FSM, bus request register and M/WB next-state logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    timeout_d      = timeout_q;
    rdata_d        = rdata_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_be_d       = bus_be_q;
    wb_MemToReg_d  = wb_MemToReg_q;
    wb_RegWrite_d  = wb_RegWrite_q;
    wb_rd_d        = wb_rd_q;
    wb_alu_out_d   = wb_alu_out_q;
    wb_mem_rdata_d = wb_mem_rdata_q;
    fault_d        = 1'b0;
    cause_d        = FC_NONE;
    faddr_d        = '0;
    stall_c        = 1'b0;

    case (state_q)
      IDLE: begin
        if (is_mem && acc_fault == FC_NONE) begin
          stall_c       = 1'b1;
          bus_req_d     = 1'b1;
          bus_we_d      = m_MemWrite;
          bus_addr_d    = {m_alu_out[31:2], 2'b00};
          bus_be_d      = lane_be;
          bus_wdata_d   = m_MemWrite ? lane_wdata : '0;
          cnt_d         = '0;
          timeout_d     = 1'b0;
          state_d       = BUSY;
          // Bubble into WB while the access is in flight.
          wb_MemToReg_d = 1'b0;
          wb_RegWrite_d = 1'b0;
        end else begin
          wb_MemToReg_d  = m_MemToReg;
          wb_RegWrite_d  = m_RegWrite & ~is_mem;
          wb_rd_d        = m_rd;
          wb_alu_out_d   = m_alu_out;
          wb_mem_rdata_d = '0;
          if (is_mem) begin
            fault_d = 1'b1;
            cause_d = acc_fault;
            faddr_d = m_alu_out;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (bus_ack) begin
          bus_req_d = 1'b0;
          rdata_d   = bus_rdata;
          state_d   = DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          bus_req_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        wb_MemToReg_d  = m_MemToReg;
        wb_RegWrite_d  = m_RegWrite & ~timeout_q;
        wb_rd_d        = m_rd;
        wb_alu_out_d   = m_alu_out;
        wb_mem_rdata_d = (m_MemRead && !timeout_q) ? load_data : '0;
        if (timeout_q) begin
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
          faddr_d = m_alu_out;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low during reset so an aborted access releases the pipeline at once.
  assign m_stall = rst_n & stall_c;

  // State, bus and M/WB registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      rdata_q        <= '0;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_be_q       <= '0;
      wb_MemToReg_q  <= 1'b0;
      wb_RegWrite_q  <= 1'b0;
      wb_rd_q        <= '0;
      wb_alu_out_q   <= '0;
      wb_mem_rdata_q <= '0;
      fault_q        <= 1'b0;
      cause_q        <= FC_NONE;
      faddr_q        <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      rdata_q        <= rdata_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_be_q       <= bus_be_d;
      wb_MemToReg_q  <= wb_MemToReg_d;
      wb_RegWrite_q  <= wb_RegWrite_d;
      wb_rd_q        <= wb_rd_d;
      wb_alu_out_q   <= wb_alu_out_d;
      wb_mem_rdata_q <= wb_mem_rdata_d;
      fault_q        <= fault_d;
      cause_q        <= cause_d;
      faddr_q        <= faddr_d;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_be        = bus_be_q;
  assign wb_MemToReg   = wb_MemToReg_q;
  assign wb_RegWrite   = wb_RegWrite_q;
  assign wb_rd         = wb_rd_q;
  assign wb_alu_out    = wb_alu_out_q;
  assign wb_mem_rdata  = wb_mem_rdata_q;
  assign m_fault       = fault_q;
  assign m_fault_cause = cause_q;
  assign m_fault_addr  = faddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus scoreboard, and a
// hand-written mid-access reset sequence.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk, rst_n;
  logic        m_MemToReg, m_RegWrite, m_MemRead, m_MemWrite;
  logic [4:0]  m_rd;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_out, m_mem_data;
  logic        m_stall, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        wb_MemToReg, wb_RegWrite, m_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_out, wb_mem_rdata, m_fault_addr;
  logic [1:0]  m_fault_cause;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_MemToReg(m_MemToReg), .m_RegWrite(m_RegWrite),
    .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite),
    .m_rd(m_rd), .m_funct3(m_funct3), .m_alu_out(m_alu_out), .m_mem_data(m_mem_data),
    .m_stall(m_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .wb_MemToReg(wb_MemToReg), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .wb_alu_out(wb_alu_out), .wb_mem_rdata(wb_mem_rdata),
    .m_fault(m_fault), .m_fault_cause(m_fault_cause), .m_fault_addr(m_fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        mtr, rw, mr, mw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] addr, mdata, rdata;
    logic        ack_en;
    logic [3:0]  waits;
    logic [3:0]  e_stalls, e_reqs, e_be;
    logic [31:0] e_wdata;
    logic        e_rw;
    logic [31:0] e_rdata;
    logic        e_fault;
    logic [1:0]  e_cause;
  } vec_t;

  function automatic vec_t mk(input logic mtr, rw, mr, mw, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [31:0] addr, mdata, rdata,
                              input logic ack_en, input logic [3:0] waits, e_stalls, e_reqs, e_be,
                              input logic [31:0] e_wdata, input logic e_rw,
                              input logic [31:0] e_rdata, input logic e_fault,
                              input logic [1:0] e_cause);
    vec_t v;
    v.mtr = mtr; v.rw = rw; v.mr = mr; v.mw = mw; v.rd = rd; v.f3 = f3;
    v.addr = addr; v.mdata = mdata; v.rdata = rdata; v.ack_en = ack_en; v.waits = waits;
    v.e_stalls = e_stalls; v.e_reqs = e_reqs; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_rw = e_rw; v.e_rdata = e_rdata; v.e_fault = e_fault; v.e_cause = e_cause;
    return v;
  endfunction

  vec_t sb[$];
  vec_t tv[15];

  task automatic drive(input vec_t v);
    m_MemToReg = v.mtr; m_RegWrite = v.rw; m_MemRead = v.mr; m_MemWrite = v.mw;
    m_rd = v.rd; m_funct3 = v.f3; m_alu_out = v.addr; m_mem_data = v.mdata;
  endtask

  // Issue one instruction, play the bus slave, and compare M/WB at capture.
  task automatic run(input int idx, input vec_t v);
    int  stalls, reqs;
    bit  done;
    vec_t e;
    drive(v);
    sb.push_back(v);
    stalls = 0; reqs = 0; done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (m_stall) stalls++;
      else done = 1;
      if (bus_req) begin
        reqs++;
        check($sformatf("v%0d_bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
        check($sformatf("v%0d_bus_be", idx), {28'b0, bus_be}, {28'b0, v.e_be});
        check($sformatf("v%0d_bus_we", idx), {31'b0, bus_we}, {31'b0, v.mw});
        if (v.mw) check($sformatf("v%0d_bus_wdata", idx), bus_wdata, v.e_wdata);
        if (v.ack_en && reqs == int'(v.waits) + 1) begin
          bus_ack = 1'b1;
          bus_rdata = v.rdata;
        end
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = 32'h0;
    end
    if (!done) check($sformatf("v%0d_capture_bound", idx), 32'd0, 32'd1);
    check($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.e_stalls));
    check($sformatf("v%0d_req_cycles", idx), 32'(reqs), 32'(v.e_reqs));
    if (sb.size() == 0) begin
      check($sformatf("v%0d_scoreboard_empty", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d_wb_RegWrite", idx), {31'b0, wb_RegWrite}, {31'b0, e.e_rw});
      check($sformatf("v%0d_wb_MemToReg", idx), {31'b0, wb_MemToReg}, {31'b0, e.mtr});
      check($sformatf("v%0d_wb_rd", idx), {27'b0, wb_rd}, {27'b0, e.rd});
      check($sformatf("v%0d_wb_alu_out", idx), wb_alu_out, e.addr);
      check($sformatf("v%0d_wb_mem_rdata", idx), wb_mem_rdata, e.e_rdata);
      check($sformatf("v%0d_m_fault", idx), {31'b0, m_fault}, {31'b0, e.e_fault});
      check($sformatf("v%0d_fault_cause", idx), {30'b0, m_fault_cause}, {30'b0, e.e_cause});
      check($sformatf("v%0d_fault_addr", idx), m_fault_addr, e.e_fault ? e.addr : 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          mtr rw mr mw rd  f3     addr          mdata         rdata         ack w  st rq be       wdata         erw erdata        flt cause
    tv[0]  = mk(0, 1, 0, 0, 5,  F3_B,  32'h0000_1234, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'h0,        0, FC_NONE);
    tv[1]  = mk(1, 1, 1, 0, 6,  F3_B,  32'h0000_0103, 32'h0,        32'h8011_2233, 1, 0, 2, 1, 4'b1000, 32'h0,        1, 32'hFFFF_FF80, 0, FC_NONE);
    tv[2]  = mk(1, 1, 1, 0, 6,  F3_BU, 32'h0000_0103, 32'h0,        32'h8011_2233, 1, 0, 2, 1, 4'b1000, 32'h0,        1, 32'h0000_0080, 0, FC_NONE);
    tv[3]  = mk(0, 0, 0, 1, 0,  F3_H,  32'h0000_0202, 32'h0000_ABCD, 32'h0,       1, 3, 5, 4, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,        0, FC_NONE);
    tv[4]  = mk(1, 1, 1, 0, 7,  F3_W,  32'h0000_0301, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, FC_MISALIGN);
    tv[5]  = mk(1, 1, 1, 0, 8,  F3_HU, 32'h0000_0502, 32'h0,        32'h8001_7FFF, 1, 1, 3, 2, 4'b1100, 32'h0,        1, 32'h0000_8001, 0, FC_NONE);
    tv[6]  = mk(1, 1, 1, 0, 8,  F3_H,  32'h0000_0500, 32'h0,        32'h1234_8765, 1, 0, 2, 1, 4'b0011, 32'h0,        1, 32'hFFFF_8765, 0, FC_NONE);
    tv[7]  = mk(0, 0, 0, 1, 0,  F3_B,  32'h0000_0601, 32'h1234_565A, 32'h0,       1, 0, 2, 1, 4'b0010, 32'h5A5A_5A5A, 0, 32'h0,        0, FC_NONE);
    tv[8]  = mk(0, 0, 0, 1, 0,  F3_W,  32'h0000_0704, 32'hDEAD_BEEF, 32'h0,       1, 2, 4, 3, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,        0, FC_NONE);
    tv[9]  = mk(1, 1, 1, 0, 9,  F3_W,  32'h0000_0400, 32'h0,        32'h0,        0, 0, 5, 4, 4'b1111, 32'h0,        0, 32'h0,        1, FC_TIMEOUT);
    tv[10] = mk(1, 1, 1, 0, 10, 3'b011, 32'h0000_0404, 32'h0,       32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, FC_ILLEGAL);
    tv[11] = mk(1, 1, 1, 1, 11, F3_W,  32'h0000_0408, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, FC_ILLEGAL);
    tv[12] = mk(0, 0, 0, 1, 0,  F3_H,  32'h0000_0203, 32'h0000_1111, 32'h0,       0, 0, 0, 0, 4'b0000, 32'h0,        0, 32'h0,        1, FC_MISALIGN);
    tv[13] = mk(1, 1, 1, 0, 12, F3_W,  32'h0000_0800, 32'h0,        32'hCAFE_BABE, 1, 0, 2, 1, 4'b1111, 32'h0,        1, 32'hCAFE_BABE, 0, FC_NONE);
    tv[14] = mk(0, 1, 0, 0, 13, F3_B,  32'hFFFF_0001, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'h0,        0, FC_NONE);

    // Reset state.
    rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    drive('0);
    #12;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_m_stall", {31'b0, m_stall}, 32'd0);
    check("rst_wb_RegWrite", {31'b0, wb_RegWrite}, 32'd0);
    check("rst_wb_alu_out", wb_alu_out, 32'd0);
    check("rst_m_fault", {31'b0, m_fault}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run(i, tv[i]);

    // Mid-access reset: abort while BUSY, then a stray ack must be ignored.
    drive(tv[13]);
    @(negedge clk);
    check("mr_stall_idle", {31'b0, m_stall}, 32'd1);
    @(posedge clk); #1;
    check("mr_bus_req_busy", {31'b0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_bus_req_async", {31'b0, bus_req}, 32'd0);
    check("mr_stall_async", {31'b0, m_stall}, 32'd0);
    drive('0);
    @(negedge clk); rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("mr_stray_ack_req", {31'b0, bus_req}, 32'd0);
    check("mr_stray_ack_stall", {31'b0, m_stall}, 32'd0);
    check("mr_stray_ack_wb", {31'b0, wb_RegWrite}, 32'd0);
    @(posedge clk); #1;
    check("mr_stray_ack_rdata", wb_mem_rdata, 32'd0);
    run(15, tv[13]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the CPU. Consumes the EX/M buffer outputs, performs loads and stores over a single-outstanding request/acknowledge data bus, and stalls the upstream pipeline while an access is in flight. It contains the M/WB pipeline register, which holds the writeback controls, the ALU result and the aligned load data. It also detects misaligned, illegal and timed-out accesses.

## Interface
- TIMEOUT_CYCLES, 255: number of BUSY cycles without ack before a bus timeout; 0 disables the timeout.
- clk  in  1  pipeline clock; the block uses one clock.
- rst_n  in  1  reset, asynchronous and active-low.
- m_MemToReg, m_RegWrite, m_MemRead, m_MemWrite  in  1 each  controls from the EX/M buffer.
- m_rd  in  5  destination register.
- m_funct3  in  3  access size and sign; the EX/M buffer carries it alongside the other M controls.
- m_alu_out  in  32  effective address, or result of a non-memory instruction.
- m_mem_data  in  32  store data from rs2.
- m_stall  out  1  holds the PC, IF/ID, ID/EX and EX/M registers.
- bus_req, bus_we  out  1 each  request, and write-not-read.
- bus_addr  out  32  word address; bits [1:0] are 0.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_rdata  in  32  read data; valid only when bus_ack=1.
- bus_ack  in  1  one-cycle completion pulse.
- wb_MemToReg, wb_RegWrite  out  1 each  writeback controls.
- wb_rd  out  5  destination register for writeback.
- wb_alu_out  out  32  registered ALU result.
- wb_mem_rdata  out  32  registered, aligned and extended load data.
- m_fault  out  1  one-cycle fault pulse.
- m_fault_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal access.
- m_fault_addr  out  32  m_alu_out of the faulting access.

## Operation
- **funct3 encoding:** 000 B, 001 H, 010 W, 100 BU, 101 HU. Codes 011, 110 and 111 on a memory op are illegal. MemRead and MemWrite asserted together are also illegal (cause 11).
- **Misaligned:** H or HU with addr[0]=1; W with addr[1:0]≠0. Cause 01.
- **FSM IDLE:**
  - Non-memory op: no stall; M/WB captures at the next edge.
  - Faulting memory op: no stall and no bus request. M/WB captures with wb_RegWrite forced to 0; m_fault and cause are registered at the same edge.
  - Legal memory op: m_stall=1 combinationally. Register bus_req=1, bus_we, bus_addr={addr[31:2],2'b00}, bus_be and bus_wdata; go to BUSY.
- **FSM BUSY:**
  - m_stall=1. bus_req and the other bus outputs are held stable.
  - On bus_ack: drop bus_req, capture bus_rdata into an internal register, go to DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES without ack: drop bus_req, set a timeout flag, go to DONE.
- **FSM DONE:**
  - m_stall=0 so the pipeline advances.
  - At the edge, M/WB captures. On timeout, wb_RegWrite is forced to 0 and m_fault is pulsed with cause 10.
  - Return to IDLE.
- **Store lanes:**
  - SB: be=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
- **Load lanes:** select byte addr[1:0] or half addr[1], then zero- or sign-extend to 32 bits. Stores write wb_mem_rdata=0.
- **Ignored conditions:** bus_ack outside BUSY is ignored; m_stall is never asserted in DONE.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0. Reset mid-access drops bus_req immediately and discards the access.
- **Zero-wait memory** (ack in the first BUSY cycle): m_stall is high for 2 cycles, and the instruction spends 3 cycles in M.
- **Wait states:** each extra wait state adds one stall cycle.
- **Handshake:** at most one request is outstanding. bus_req rises only from IDLE, and falls in the cycle after the ack is sampled.
- **Faults:** m_fault is high for exactly one cycle, coincident with the M/WB update of the faulting instruction. Cause and address are valid in that cycle; otherwise they are 0.
- **Timeout counter:** width $clog2(TIMEOUT_CYCLES+1); it clears on entry to BUSY.

## Structure
- **Package mem_pkg:**
  - state enum {IDLE, BUSY, DONE};
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - fault-cause constants (FC_MISALIGN, FC_TIMEOUT, FC_ILLEGAL).
- **Sub-module lsu_load_align:** combinational. Inputs rdata[31:0], addr[1:0] and funct3; output data[31:0].

## Test plan
- **ALU pass-through:** m_RegWrite=1, m_alu_out=0x1234, no memory op → next cycle wb_alu_out=0x1234, wb_RegWrite=1, m_stall never 1.
- **Zero-wait LB:** addr 0x103, bus_rdata=0x80xxxxxx, ack in the first BUSY cycle → bus_addr=0x100, m_stall high for 2 cycles, wb_mem_rdata=0xFFFFFF80. The same access as LBU → 0x00000080.
- **SH with waits:** addr 0x202, data 0xABCD, ack after 3 wait states → be=1100, wdata=0xABCDABCD, bus_we=1, m_stall high for 5 cycles, wb_RegWrite=0.
- **Misaligned LW:** addr 0x301 → no bus_req, m_fault=1, cause 01, m_fault_addr=0x301, wb_RegWrite=0.
- **Timeout:** TIMEOUT_CYCLES=4, no ack → bus_req high for 4 cycles then drops, cause 10, wb_RegWrite=0.
- **Mid-access reset:** rst_n low in BUSY → bus_req and m_stall go 0 asynchronously. A later ack is ignored.
